// File: rtl/nic_pkg.sv
// Shared constants for the NIC: PE register map addresses and status word layout.
package nic_pkg;

  localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  // Status word: bit0 is a direction-specific flag, occupancy count sits just above it.
  localparam int STAT_FLAG_BIT = 0;
  localparam int STAT_CNT_LSB  = 1;

endpackage

// File: rtl/nic_sync_fifo.sv
// Show-ahead synchronous FIFO; the parent decides when push/pop are legal.
module nic_sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  // Empty reads as zero so neither consumer ever sees stale storage.
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nic_fifo.sv
// NIC between a PE register port and a router port, with a DEPTH-entry FIFO per direction
// and virtual-channel gating of the outbound head packet.
module nic_fifo
  import nic_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4,
  parameter int VC_BIT = 63
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nicEn,
  input  logic              nicWrEN,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [DATA_W-1:0] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [DATA_W-1:0] net_do,
  input  logic              net_polarity
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] in_head, out_head;
  logic              in_full, in_empty, out_full, out_empty;
  logic [CNT_W-1:0]  in_count, out_count;
  logic              pe_rd, pe_wr;
  logic              in_push, in_pop, out_push, out_pop;
  logic [DATA_W-1:0] in_stat, out_stat;

  assign pe_rd = nicEn && !nicWrEN;
  assign pe_wr = nicEn && nicWrEN;

  assign net_ri  = !reset && !in_full;
  assign in_push = net_si && net_ri;
  assign in_pop  = pe_rd && (addr == ADDR_IN_DATA) && !in_empty;

  // The head only leaves when its VC matches the router phase; no packet may overtake it.
  assign net_so   = !out_empty && (out_head[VC_BIT] == net_polarity);
  assign net_do   = out_head;
  assign out_pop  = net_so && net_ro;
  assign out_push = pe_wr && (addr == ADDR_OUT_DATA) && (!out_full || out_pop);

  always_comb begin
    in_stat                             = '0;
    in_stat[STAT_FLAG_BIT]              = !in_empty;
    in_stat[STAT_CNT_LSB +: CNT_W]      = in_count;
    out_stat                            = '0;
    out_stat[STAT_FLAG_BIT]             = out_full;
    out_stat[STAT_CNT_LSB +: CNT_W]     = out_count;
  end

  nic_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_push),
    .pop   (in_pop),
    .din   (net_di),
    .dout  (in_head),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count)
  );

  nic_sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .din   (d_in),
    .dout  (out_head),
    .full  (out_full),
    .empty (out_empty),
    .count (out_count)
  );

  // Reads of the output data address have no meaning, so d_out holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_out <= '0;
    end else if (pe_rd) begin
      case (addr)
        ADDR_IN_DATA:  d_out <= in_head;
        ADDR_IN_STAT:  d_out <= in_stat;
        ADDR_OUT_STAT: d_out <= out_stat;
        default:       d_out <= d_out;
      endcase
    end
  end

endmodule
